pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 32: instruction payload width.
REQ-002 Parameter PC_W, default 32: PC width.
REQ-003 Parameter PC_INC, default 4: constant added to captured PC.
REQ-004 Parameter CNT_W, default 8: stall counter width.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 in_valid  input  1  upstream holds a valid instruction.
REQ-008 in_ready  output  1  stage can accept input this cycle.
REQ-009 in_pc  input  PC_W  PC of the upstream instruction.
REQ-010 in_instr  input  DATA_W  upstream instruction word.
REQ-011 nullify  input  1  kill the instruction being accepted this cycle.
REQ-012 flush  input  1  discard all stage contents.
REQ-013 out_valid  output  1  stage presents a valid entry.
REQ-014 out_ready  input  1  downstream accepts the entry this cycle.
REQ-015 out_pc4  output  PC_W  captured PC plus PC_INC.
REQ-016 out_instr  output  DATA_W  captured instruction.
REQ-017 stall_cnt  output  CNT_W  consecutive cycles the current entry has waited.

Function
REQ-018 Input handshake: in_valid & in_ready at a rising edge; output handshake: out_valid & out_ready at a rising edge.
REQ-019 Captured out_pc4 SHALL be (in_pc + PC_INC) mod 2^PC_W; latency in to out is exactly 1 cycle when the stage is empty.
REQ-020 Nullify with an input handshake: input consumed; no entry is created; payload registers load zero.
REQ-021 Nullify without an input handshake: no effect.
REQ-022 Flush: priority over all other events.
REQ-023 Flush SHALL clear every entry, all payload to zero and out_valid to 0 at that edge.
REQ-024 Any input handshake in the flush cycle SHALL be consumed and discarded.
REQ-025 Core FSM states: EMPTY (out_valid=0), FULL (out_valid=1).
REQ-026 EMPTY to FULL on an input handshake without nullify.
REQ-027 FULL to EMPTY on an output handshake with no non-nullified input handshake.
REQ-028 FULL stays FULL with a new payload when both handshakes occur in the same cycle.
REQ-029 Stall (out_valid & ~out_ready): payload and out_valid SHALL hold unchanged.
REQ-030 stall_cnt SHALL increment each stalled cycle and saturate at 2^CNT_W-1.
REQ-031 stall_cnt SHALL clear to 0 on an output handshake, on flush, or in EMPTY.

Reset
REQ-032 Assertion (reset=0) SHALL immediately force out_valid=0, out_pc4=0, out_instr=0, stall_cnt=0 and all skid storage to zero, independent of clk.
REQ-033 Reset mid-transfer SHALL drop all held entries; after deassertion the first accepted instruction appears one cycle later.

Configuration
REQ-034 Macro PIPE_STAGE_REG_SKID_EN selects the skid buffer.
REQ-035 Without the macro: in_ready = ~out_valid | out_ready, combinational; capacity 1.
REQ-036 With the macro: a third state, SKID, holds one extra entry; capacity is 2.
REQ-037 With the macro: in_ready SHALL be registered, equal to (state != SKID).
REQ-038 With the macro: FULL to SKID on a non-nullified input handshake while stalled.
REQ-039 With the macro: SKID to FULL on an output handshake; the skid entry moves to the output the next cycle in arrival order.
REQ-040 Flush or reset in SKID SHALL clear both entries.

Verification
REQ-041 Empty stage, in_valid=1, in_pc=0x3000, in_instr=0x24010005, out_ready=1 -> next cycle out_valid=1, out_pc4=0x3004, out_instr=0x24010005.
REQ-042 in_pc=0xFFFFFFFC, PC_INC=4 -> out_pc4=0x00000000.
REQ-043 FULL, out_ready=0 for 300 cycles, CNT_W=8 -> payload constant, stall_cnt reaches 255 and holds; out_ready=1 -> stall_cnt=0.
REQ-044 nullify=1 with in_valid=1 on an empty stage -> out_valid=0, out_instr=0; flush=1 with in_valid=1 while FULL -> out_valid=0, input dropped.
REQ-045 Macro set, stalled FULL holding A, accept B -> in_ready=0 next cycle; out_ready=1 -> A then B delivered in consecutive cycles, then in_ready=1.
REQ-046 reset pulsed low mid-cycle while SKID -> outputs zero before the next clk edge; in_ready=1 after release.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: one pipeline register stage capturing PC+PC_INC and the instruction, with nullify, flush and stall counter.
// Define PIPE_STAGE_REG_SKID_EN to add a one-entry skid buffer and a registered in_ready.
module pipe_stage_reg #(
   parameter int DATA_W = 32,
   parameter int PC_W   = 32,
   parameter int PC_INC = 4,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PC_W-1:0]   in_pc,
   input  logic [DATA_W-1:0] in_instr,
   input  logic              nullify,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PC_W-1:0]   out_pc4,
   output logic [DATA_W-1:0] out_instr,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam logic [1:0]        ST_EMPTY   = 2'b00;
   localparam logic [1:0]        ST_FULL    = 2'b01;
`ifdef PIPE_STAGE_REG_SKID_EN
   localparam logic [1:0]        ST_SKID    = 2'b10;
`endif
   localparam logic [PC_W-1:0]   PC_ZERO    = {PC_W{1'b0}};
   localparam logic [DATA_W-1:0] INSTR_ZERO = {DATA_W{1'b0}};
   localparam logic [CNT_W-1:0]  CNT_ZERO   = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1'b1);
   localparam logic [PC_W-1:0]   PC_INC_C   = PC_W'(PC_INC);

   logic [1:0]        state_r, state_s;
   logic              out_valid_r;
   logic [PC_W-1:0]   pc4_r, pc4_s;
   logic [DATA_W-1:0] instr_r, instr_s;
   logic [CNT_W-1:0]  cnt_r, cnt_s;
   logic [PC_W-1:0]   in_pc4_s;
   logic              in_ready_s, in_hs_s, take_s, out_hs_s;
`ifdef PIPE_STAGE_REG_SKID_EN
   logic              in_ready_r;
   logic [PC_W-1:0]   skid_pc4_r, skid_pc4_s;
   logic [DATA_W-1:0] skid_instr_r, skid_instr_s;

   assign in_ready_s = in_ready_r;
`else
   assign in_ready_s = ~out_valid_r | out_ready;
`endif

   assign in_pc4_s = in_pc + PC_INC_C;
   assign in_hs_s  = in_valid & in_ready_s;
   assign take_s   = in_hs_s & ~nullify;
   assign out_hs_s = out_valid_r & out_ready;

   // Next state and payload; a nullified handshake still consumes the input but zeroes its destination.
   always_comb begin
      state_s = state_r;
      pc4_s   = pc4_r;
      instr_s = instr_r;
`ifdef PIPE_STAGE_REG_SKID_EN
      skid_pc4_s   = skid_pc4_r;
      skid_instr_s = skid_instr_r;
`endif
      if (flush) begin
         state_s = ST_EMPTY;
         pc4_s   = PC_ZERO;
         instr_s = INSTR_ZERO;
`ifdef PIPE_STAGE_REG_SKID_EN
         skid_pc4_s   = PC_ZERO;
         skid_instr_s = INSTR_ZERO;
`endif
      end else begin
         case (state_r)
            ST_EMPTY: begin
               if (take_s) begin
                  state_s = ST_FULL;
                  pc4_s   = in_pc4_s;
                  instr_s = in_instr;
               end else if (in_hs_s) begin
                  pc4_s   = PC_ZERO;
                  instr_s = INSTR_ZERO;
               end else begin
                  state_s = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (out_hs_s && take_s) begin
                  pc4_s   = in_pc4_s;
                  instr_s = in_instr;
               end else if (out_hs_s && in_hs_s) begin
                  state_s = ST_EMPTY;
                  pc4_s   = PC_ZERO;
                  instr_s = INSTR_ZERO;
               end else if (out_hs_s) begin
                  state_s = ST_EMPTY;
               end
`ifdef PIPE_STAGE_REG_SKID_EN
               else if (take_s) begin
                  state_s      = ST_SKID;
                  skid_pc4_s   = in_pc4_s;
                  skid_instr_s = in_instr;
               end else if (in_hs_s) begin
                  skid_pc4_s   = PC_ZERO;
                  skid_instr_s = INSTR_ZERO;
               end
`endif
               else begin
                  state_s = ST_FULL;
               end
            end
`ifdef PIPE_STAGE_REG_SKID_EN
            ST_SKID: begin
               if (out_hs_s) begin
                  state_s      = ST_FULL;
                  pc4_s        = skid_pc4_r;
                  instr_s      = skid_instr_r;
                  skid_pc4_s   = PC_ZERO;
                  skid_instr_s = INSTR_ZERO;
               end else begin
                  state_s = ST_SKID;
               end
            end
`endif
            default: begin
               state_s = ST_EMPTY;
               pc4_s   = PC_ZERO;
               instr_s = INSTR_ZERO;
            end
         endcase
      end
   end

   // Stall counter: counts held cycles of the presented entry, saturating.
   always_comb begin
      cnt_s = cnt_r;
      if (flush || out_hs_s || !out_valid_r) begin
         cnt_s = CNT_ZERO;
      end else if (cnt_r != CNT_MAX) begin
         cnt_s = cnt_r + CNT_ONE;
      end else begin
         cnt_s = cnt_r;
      end
   end

   // State, payload and counter registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r      <= ST_EMPTY;
         out_valid_r  <= 1'b0;
         pc4_r        <= PC_ZERO;
         instr_r      <= INSTR_ZERO;
         cnt_r        <= CNT_ZERO;
`ifdef PIPE_STAGE_REG_SKID_EN
         in_ready_r   <= 1'b1;
         skid_pc4_r   <= PC_ZERO;
         skid_instr_r <= INSTR_ZERO;
`endif
      end else begin
         state_r      <= state_s;
         out_valid_r  <= (state_s != ST_EMPTY);
         pc4_r        <= pc4_s;
         instr_r      <= instr_s;
         cnt_r        <= cnt_s;
`ifdef PIPE_STAGE_REG_SKID_EN
         in_ready_r   <= (state_s != ST_SKID);
         skid_pc4_r   <= skid_pc4_s;
         skid_instr_r <= skid_instr_s;
`endif
      end
   end

   assign in_ready  = in_ready_s;
   assign out_valid = out_valid_r;
   assign out_pc4   = pc4_r;
   assign out_instr = instr_r;
   assign stall_cnt = cnt_r;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios plus randomized traffic against a queue-based model.
module tb_pipe_stage_reg;
   localparam int DATA_W = 32;
   localparam int PC_W   = 32;
   localparam int PC_INC = 4;
   localparam int CNT_W  = 8;
`ifdef PIPE_STAGE_REG_SKID_EN
   localparam int CAP = 2;
`else
   localparam int CAP = 1;
`endif

   logic              clk = 1'b0;
   logic              reset;
   logic              in_valid, nullify, flush, out_ready;
   logic [PC_W-1:0]   in_pc;
   logic [DATA_W-1:0] in_instr;
   logic              in_ready, out_valid;
   logic [PC_W-1:0]   out_pc4;
   logic [DATA_W-1:0] out_instr;
   logic [CNT_W-1:0]  stall_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic [PC_W-1:0]   pc4;
      logic [DATA_W-1:0] instr;
   } entry_t;

   // Model: ordered queue of held entries, stall count, whether an empty stage shows zero payload.
   entry_t q[$];
   int     m_cnt;
   bit     m_zero;
   bit     m_rdy_reg;

   pipe_stage_reg #(.DATA_W(DATA_W), .PC_W(PC_W), .PC_INC(PC_INC), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
      .in_instr(in_instr), .nullify(nullify), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .out_pc4(out_pc4), .out_instr(out_instr), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   function automatic bit m_in_ready();
      if (CAP == 2) return m_rdy_reg;
      return (q.size() == 0) || (out_ready == 1'b1);
   endfunction

   task automatic model_reset();
      q.delete();
      m_cnt     = 0;
      m_zero    = 1'b1;
      m_rdy_reg = 1'b1;
   endtask

   task automatic drive(input bit v, input logic [PC_W-1:0] pc, input logic [DATA_W-1:0] ins,
                        input bit nul, input bit fl, input bit ordy);
      in_valid  = v;
      in_pc     = pc;
      in_instr  = ins;
      nullify   = nul;
      flush     = fl;
      out_ready = ordy;
   endtask

   // Advance one clock and apply the stage rules to the model; returns at the following falling edge.
   task automatic clock_step();
      bit rdy, ohs, ihs;
      rdy = m_in_ready();
      @(posedge clk);
      if (flush) begin
         q.delete();
         m_cnt  = 0;
         m_zero = 1'b1;
      end else begin
         ohs = (q.size() > 0) && out_ready;
         ihs = in_valid && rdy;
         if (q.size() == 0 || ohs) m_cnt = 0;
         else if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
         if (ohs) void'(q.pop_front());
         if (ihs && !nullify) q.push_back(entry_t'{pc4: in_pc + PC_W'(PC_INC), instr: in_instr});
         if (q.size() == 0) begin
            if (ihs && nullify) m_zero = 1'b1;
            else if (ohs) m_zero = 1'b0;
         end
      end
      m_rdy_reg = (q.size() < CAP);
      @(negedge clk);
   endtask

   task automatic test_reset();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      #12;
      n_checks++;
      if (out_valid !== 1'b0 || out_pc4 !== 32'h0 || out_instr !== 32'h0 || stall_cnt !== 8'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: got v=%0b pc4=%h instr=%h cnt=%0d, want all zero", out_valid, out_pc4, out_instr, stall_cnt);
      end
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_in_ready: got %0b want 1", in_ready);
      end
      @(negedge clk);
      reset = 1'b1;
      model_reset();
   endtask

   task automatic test_basic();
      drive(1'b1, 32'h3000, 32'h24010005, 1'b0, 1'b0, 1'b1);
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_in_ready: got %0b want 1", in_ready);
      end
      clock_step();
      n_checks++;
      if (out_valid !== 1'b1 || out_pc4 !== 32'h3004 || out_instr !== 32'h24010005) begin
         n_fail++;
         $display("FAIL basic_capture: got v=%0b pc4=%h instr=%h want 1/3004/24010005", out_valid, out_pc4, out_instr);
      end
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      clock_step();
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_drain: got v=%0b want 0", out_valid);
      end
   endtask

   task automatic test_wrap();
      drive(1'b1, 32'hFFFFFFFC, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1);
      clock_step();
      n_checks++;
      if (out_valid !== 1'b1 || out_pc4 !== 32'h0 || out_instr !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL pc_wrap: got v=%0b pc4=%h instr=%h want 1/00000000/deadbeef", out_valid, out_pc4, out_instr);
      end
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      clock_step();
   endtask

   task automatic test_stall_sat();
      int exp_cnt;
      drive(1'b1, 32'h100, 32'hA5A5C3C3, 1'b0, 1'b0, 1'b0);
      clock_step();
      n_checks++;
      if (out_valid !== 1'b1 || stall_cnt !== 8'd0) begin
         n_fail++;
         $display("FAIL stall_load: got v=%0b cnt=%0d want 1/0", out_valid, stall_cnt);
      end
      for (int i = 0; i < 300; i++) begin
         drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
         clock_step();
         exp_cnt = (i + 1 > 255) ? 255 : i + 1;
         n_checks++;
         if (stall_cnt !== CNT_W'(exp_cnt) || out_valid !== 1'b1 || out_pc4 !== 32'h104 || out_instr !== 32'hA5A5C3C3) begin
            n_fail++;
            $display("FAIL stall_hold[%0d]: got cnt=%0d v=%0b pc4=%h instr=%h want %0d/1/104/a5a5c3c3",
                     i, stall_cnt, out_valid, out_pc4, out_instr, exp_cnt);
         end
      end
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      clock_step();
      n_checks++;
      if (stall_cnt !== 8'd0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_release: got cnt=%0d v=%0b want 0/0", stall_cnt, out_valid);
      end
   endtask

   task automatic test_nullify_flush();
      drive(1'b1, 32'h200, 32'h11112222, 1'b1, 1'b0, 1'b1);
      clock_step();
      n_checks++;
      if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_pc4 !== 32'h0) begin
         n_fail++;
         $display("FAIL nullify_empty: got v=%0b pc4=%h instr=%h want 0/0/0", out_valid, out_pc4, out_instr);
      end
      drive(1'b1, 32'h300, 32'h33334444, 1'b0, 1'b0, 1'b0);
      clock_step();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      clock_step();
      n_checks++;
      if (out_valid !== 1'b1 || out_pc4 !== 32'h304 || stall_cnt !== 8'd1) begin
         n_fail++;
         $display("FAIL flush_setup: got v=%0b pc4=%h cnt=%0d want 1/304/1", out_valid, out_pc4, stall_cnt);
      end
      drive(1'b1, 32'h400, 32'h55556666, 1'b0, 1'b1, 1'b1);
      clock_step();
      n_checks++;
      if (out_valid !== 1'b0 || out_pc4 !== 32'h0 || out_instr !== 32'h0 || stall_cnt !== 8'd0) begin
         n_fail++;
         $display("FAIL flush_clear: got v=%0b pc4=%h instr=%h cnt=%0d want 0/0/0/0", out_valid, out_pc4, out_instr, stall_cnt);
      end
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      clock_step();
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_drop: got v=%0b want 0", out_valid);
      end
   endtask

`ifdef PIPE_STAGE_REG_SKID_EN
   task automatic test_skid();
      drive(1'b1, 32'h600, 32'hAAAA0001, 1'b0, 1'b0, 1'b0);
      clock_step();
      drive(1'b1, 32'h700, 32'hBBBB0002, 1'b0, 1'b0, 1'b0);
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL skid_accept_b: got in_ready=%0b want 1", in_ready);
      end
      clock_step();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      #1;
      n_checks++;
      if (in_ready !== 1'b0 || out_pc4 !== 32'h604 || out_instr !== 32'hAAAA0001) begin
         n_fail++;
         $display("FAIL skid_full: got rdy=%0b pc4=%h instr=%h want 0/604/aaaa0001", in_ready, out_pc4, out_instr);
      end
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      clock_step();
      n_checks++;
      if (out_valid !== 1'b1 || out_pc4 !== 32'h704 || out_instr !== 32'hBBBB0002) begin
         n_fail++;
         $display("FAIL skid_order: got v=%0b pc4=%h instr=%h want 1/704/bbbb0002", out_valid, out_pc4, out_instr);
      end
      clock_step();
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL skid_drain: got v=%0b rdy=%0b want 0/1", out_valid, in_ready);
      end
   endtask
`endif

   task automatic test_random();
      bit exp_v;
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 9) < 7, $urandom, $urandom, $urandom_range(0, 9) == 0,
               $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 6);
         #1;
         n_checks++;
         if (in_ready !== m_in_ready()) begin
            n_fail++;
            $display("FAIL rand_in_ready[%0d]: got %0b want %0b", i, in_ready, m_in_ready());
         end
         clock_step();
         exp_v = (q.size() != 0);
         n_checks++;
         if (out_valid !== exp_v || stall_cnt !== CNT_W'(m_cnt)) begin
            n_fail++;
            $display("FAIL rand_state[%0d]: got v=%0b cnt=%0d want %0b/%0d", i, out_valid, stall_cnt, exp_v, m_cnt);
         end
         if (exp_v) begin
            n_checks++;
            if (out_pc4 !== q[0].pc4 || out_instr !== q[0].instr) begin
               n_fail++;
               $display("FAIL rand_payload[%0d]: got %h/%h want %h/%h", i, out_pc4, out_instr, q[0].pc4, q[0].instr);
            end
         end else if (m_zero) begin
            n_checks++;
            if (out_pc4 !== 32'h0 || out_instr !== 32'h0) begin
               n_fail++;
               $display("FAIL rand_zero[%0d]: got %h/%h want 0/0", i, out_pc4, out_instr);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      clock_step();
      drive(1'b1, 32'h800, 32'hCCCC0003, 1'b0, 1'b0, 1'b0);
      clock_step();
      drive(1'b1, 32'h900, 32'hDDDD0004, 1'b0, 1'b0, 1'b0);
      clock_step();
      #2;
      reset = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || out_pc4 !== 32'h0 || out_instr !== 32'h0 || stall_cnt !== 8'h0) begin
         n_fail++;
         $display("FAIL reset_mid: got v=%0b pc4=%h instr=%h cnt=%0d want all zero", out_valid, out_pc4, out_instr, stall_cnt);
      end
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      drive(1'b1, 32'hA00, 32'hEEEE0005, 1'b0, 1'b0, 1'b1);
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release_ready: got %0b want 1", in_ready);
      end
      clock_step();
      n_checks++;
      if (out_valid !== 1'b1 || out_pc4 !== 32'hA04 || out_instr !== 32'hEEEE0005) begin
         n_fail++;
         $display("FAIL reset_first_accept: got v=%0b pc4=%h instr=%h want 1/a04/eeee0005", out_valid, out_pc4, out_instr);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_stall_sat();
      test_nullify_flush();
`ifdef PIPE_STAGE_REG_SKID_EN
      test_skid();
`endif
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
